lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters; it imports the rv32i package and uses reg_we_e for its write-enable output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a memory operation.
REQ-005 req_ready  output  1  high only in IDLE; accept = req_valid && req_ready at a rising edge.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 req_addr  input  32  byte address (rs1 + imm); req_wdata  input  32  store data (rs2); req_rd  input  5  load destination.
REQ-009 mem_valid  output  1; mem_ready  input  1; mem_addr  output  32  word-aligned; mem_we  output  1; mem_wstrb  output  4; mem_wdata  output  32.
REQ-010 mem_rvalid  input  1  read data valid; mem_rdata  input  32  read word.
REQ-011 wb_we  output  reg_we_e; wb_rd  output  5; wb_data  output  32  drive the register file write port directly.
REQ-012 busy  output  1  high in any state other than IDLE; done  output  1  one-cycle completion pulse; fault  output  1  one-cycle misaligned/illegal pulse.

Function
REQ-013 States SHALL be IDLE, REQ, WAIT, WB, SDONE, FAULT, encoded as an enum.
REQ-014 On accept, the block SHALL register addr, wdata, funct3, is_store, rd; these registers SHALL NOT change until return to IDLE.
REQ-015 Fault check at accept: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 in {011,110,111}, or store funct3 >= 011 -> next state FAULT; otherwise -> REQ.
REQ-016 FAULT SHALL last one cycle with fault=1, issue no memory access, leave wb_we not enabled, then go to IDLE.
REQ-017 In REQ, mem_valid=1 and mem_addr/mem_we/mem_wstrb/mem_wdata SHALL be held stable until the cycle mem_ready=1.
REQ-018 mem_addr = {addr[31:2],2'b00}; mem_we = is_store.
REQ-019 Store lanes: SB wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}; SH wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}; SW wstrb = 4'b1111, wdata unchanged; loads drive wstrb = 4'b0000.
REQ-020 Store: mem_ready in REQ -> SDONE; SDONE lasts one cycle with done=1, then IDLE.
REQ-021 Load: mem_ready in REQ -> WAIT, or directly WB if mem_rvalid=1 in the same cycle; in WAIT, mem_rvalid=1 -> WB.
REQ-022 mem_rdata SHALL be captured in the cycle mem_rvalid=1; mem_rvalid in IDLE, REQ-without-ready, SDONE, or FAULT SHALL be ignored.
REQ-023 Load extraction: byte = word >> (8*addr[1:0]), half = word >> (16*addr[1]); LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-024 WB SHALL last one cycle: wb_we=REG_WE (only if rd!=0), wb_rd=rd, wb_data=extracted value, done=1; then IDLE.
REQ-025 Outside WB, wb_we SHALL be the non-write enumerator of reg_we_e; wb_rd and wb_data SHALL be 0.
REQ-026 Minimum latency: load accept edge -> WB 2 cycles later (ready and rvalid same cycle); store accept -> done 2 cycles later.
REQ-027 done and fault SHALL never be high in the same cycle; a new request SHALL not be accepted before the cycle after done/fault.

Reset
REQ-028 While reset=1 at a rising edge: state=IDLE, all captured registers=0.
REQ-029 Reset values of outputs: req_ready=1, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, wb_we non-write, wb_rd=0, wb_data=0, busy=0, done=0, fault=0.
REQ-030 Reset mid-transaction SHALL abandon it: no done, no wb_we, mem_valid low in the cycle after the reset edge; a late mem_rvalid SHALL be ignored.

Verification
REQ-031 LB addr=0x103, mem_rdata=0x80FF_1234, ready+rvalid same cycle -> mem_addr=0x100, wb_data=0xFFFF_FF80, wb_we=REG_WE for one cycle, 2 cycles after accept.
REQ-032 LHU addr=0x202, ready held low 3 cycles, rvalid 2 cycles after ready, rdata=0xBEEF_0000 -> mem signals stable 4 cycles, wb_data=0x0000_BEEF.
REQ-033 SB addr=0x41, wdata=0x1234_56AB -> mem_wstrb=4'b0010, mem_wdata=0xABAB_ABAB, mem_we=1, done one cycle after ready, wb_we never REG_WE.
REQ-034 LW addr=0x06 and SH addr=0x11 -> fault=1 one cycle, mem_valid never 1, busy returns 0 next cycle.
REQ-035 LW rd=0 addr=0x10 rdata=0xDEAD_BEEF -> done=1, wb_we non-write.
REQ-036 reset=1 in WAIT, rvalid pulsed the next cycle -> state IDLE, no done, no wb_we, req_ready=1.

Source files
------------

// File: rtl/rv32i.sv
// RV32I shared types: register-file write-enable encoding.
package rv32i;

   typedef enum logic {
      REG_NO_WE = 1'b0,
      REG_WE    = 1'b1
   } reg_we_e;

endpackage

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I load or store, performs a single
// word-aligned memory access, formats store lanes, extracts and extends
// load data, and drives the register-file write port for one cycle.
module lsu
   import rv32i::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output reg_we_e     wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_WB    = 3'd3,
      S_SDONE = 3'd4,
      S_FAULT = 3'd5
   } state_e;

   state_e      state;
   state_e      state_n;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        is_store_q;
   logic [4:0]  rd_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        bad_req;
   logic        load_rx;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   assign accept = req_valid && (state == S_IDLE);

   // Read data is taken only when a load is actually listening for it.
   assign load_rx = ((state == S_REQ) && mem_ready && !is_store_q && mem_rvalid) ||
                    ((state == S_WAIT) && mem_rvalid);

   // Misalignment and illegal-encoding check on the incoming request.
   always_comb begin
      bad_req = 1'b0;
      if (req_is_store) begin
         if (req_funct3 >= 3'b011) bad_req = 1'b1;
      end else begin
         if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111))
            bad_req = 1'b1;
      end
      if ((req_funct3[1:0] == 2'b01) && req_addr[0])
         bad_req = 1'b1;
      if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
         bad_req = 1'b1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Request fields, frozen from accept until the return to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         is_store_q <= 1'b0;
         rd_q       <= '0;
      end else if (accept) begin
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         funct3_q   <= req_funct3;
         is_store_q <= req_is_store;
         rd_q       <= req_rd;
      end
   end

   // Load data capture register.
   always_ff @(posedge clk) begin
      if (reset)        rdata_q <= '0;
      else if (load_rx) rdata_q <= mem_rdata;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (req_valid) state_n = bad_req ? S_FAULT : S_REQ;
         end
         S_REQ: begin
            if (mem_ready) begin
               if (is_store_q)      state_n = S_SDONE;
               else if (mem_rvalid) state_n = S_WB;
               else                 state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) state_n = S_WB;
         end
         S_WB:    state_n = S_IDLE;
         S_SDONE: state_n = S_IDLE;
         S_FAULT: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Store lane replication and byte strobes.
   always_comb begin
      st_wstrb = '0;
      st_wdata = wdata_q;
      if (is_store_q) begin
         case (funct3_q[1:0])
            2'b00: begin
               st_wstrb = 4'b0001 << addr_q[1:0];
               st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               st_wstrb = 4'b1111;
               st_wdata = wdata_q;
            end
         endcase
      end
   end

   // Load lane selection and sign/zero extension.
   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = rdata_q[7:0];
         2'b01:   ld_byte = rdata_q[15:8];
         2'b10:   ld_byte = rdata_q[23:16];
         default: ld_byte = rdata_q[31:24];
      endcase
      ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3_q)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_value = {24'd0, ld_byte};
         3'b101:  ld_value = {16'd0, ld_half};
         default: ld_value = rdata_q;
      endcase
   end

   // Output decode from state; memory and write-back buses are zero when idle.
   always_comb begin
      req_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wstrb = '0;
      mem_wdata = '0;
      wb_we     = REG_NO_WE;
      wb_rd     = '0;
      wb_data   = '0;
      done      = 1'b0;
      fault     = 1'b0;
      case (state)
         S_REQ: begin
            mem_valid = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_we    = is_store_q;
            mem_wstrb = st_wstrb;
            mem_wdata = st_wdata;
         end
         S_WB: begin
            wb_we   = (rd_q != 5'd0) ? REG_WE : REG_NO_WE;
            wb_rd   = rd_q;
            wb_data = ld_value;
            done    = 1'b1;
         end
         S_SDONE: done  = 1'b1;
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;
   import rv32i::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   reg_we_e     wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy;
   logic        done;
   logic        fault;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy), .done(done), .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      req_rd       = rd;
      chk("req_ready_before_accept", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_wbwe"},  32'(wb_we), 32'(REG_NO_WE));
      chk({tag, "_mvalid"}, 32'(mem_valid), 32'd0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();
      reset = 1'b0;

      // Reset state of every output
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mvalid", 32'(mem_valid), 32'd0);
      chk("rst_mwe", 32'(mem_we), 32'd0);
      chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
      chk("rst_mwdata", mem_wdata, 32'd0);
      chk("rst_wbwe", 32'(wb_we), 32'(REG_NO_WE));
      chk("rst_wbrd", 32'(wb_rd), 32'd0);
      chk("rst_wbdata", wb_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      // LB 0x103, ready and rvalid in the same cycle
      issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
      chk("lb_busy", 32'(busy), 32'd1);
      chk("lb_mvalid", 32'(mem_valid), 32'd1);
      chk("lb_maddr", mem_addr, 32'h0000_0100);
      chk("lb_mwe", 32'(mem_we), 32'd0);
      chk("lb_wstrb", 32'(mem_wstrb), 32'd0);
      chk("lb_ready_busy", 32'(req_ready), 32'd0);
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
      chk("lb_wbwe", 32'(wb_we), 32'(REG_WE));
      chk("lb_wbrd", 32'(wb_rd), 32'd5);
      chk("lb_wbdata", wb_data, 32'hFFFF_FF80);
      chk("lb_done", 32'(done), 32'd1);
      chk("lb_fault", 32'(fault), 32'd0);
      chk("lb_wb_mvalid", 32'(mem_valid), 32'd0);
      step();
      chk_idle("lb_after");
      chk("lb_after_wbdata", wb_data, 32'd0);

      // LHU 0x202, ready low three cycles, stray rvalid while not ready
      issue(1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd7);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; end
         else        begin mem_rvalid = 1'b0; end
         if (i == 3) mem_ready = 1'b1;
         chk("lhu_mvalid", 32'(mem_valid), 32'd1);
         chk("lhu_maddr", mem_addr, 32'h0000_0200);
         chk("lhu_mwe", 32'(mem_we), 32'd0);
         chk("lhu_wstrb", 32'(mem_wstrb), 32'd0);
         step();
      end
      mem_ready = 1'b0;
      chk("lhu_wait_mvalid", 32'(mem_valid), 32'd0);
      chk("lhu_wait_busy", 32'(busy), 32'd1);
      chk("lhu_wait_done", 32'(done), 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
      chk("lhu_wait2_done", 32'(done), 32'd0);
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      chk("lhu_wbwe", 32'(wb_we), 32'(REG_WE));
      chk("lhu_wbrd", 32'(wb_rd), 32'd7);
      chk("lhu_wbdata", wb_data, 32'h0000_BEEF);
      chk("lhu_done", 32'(done), 32'd1);
      step();
      chk_idle("lhu_after");

      // SB 0x41
      issue(1'b1, 3'b000, 32'h0000_0041, 32'h1234_56AB, 5'd9);
      chk("sb_mvalid", 32'(mem_valid), 32'd1);
      chk("sb_maddr", mem_addr, 32'h0000_0040);
      chk("sb_mwe", 32'(mem_we), 32'd1);
      chk("sb_wstrb", 32'(mem_wstrb), 32'b0010);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("sb_done", 32'(done), 32'd1);
      chk("sb_wbwe", 32'(wb_we), 32'(REG_NO_WE));
      chk("sb_mvalid_off", 32'(mem_valid), 32'd0);
      step();
      chk_idle("sb_after");

      // SH 0x22 (upper half) and SW 0x30
      issue(1'b1, 3'b001, 32'h0000_0022, 32'hAAAA_5678, 5'd0);
      chk("sh_wstrb", 32'(mem_wstrb), 32'b1100);
      chk("sh_wdata", mem_wdata, 32'h5678_5678);
      chk("sh_maddr", mem_addr, 32'h0000_0020);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("sh_done", 32'(done), 32'd1);
      step();
      issue(1'b1, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 5'd0);
      chk("sw_wstrb", 32'(mem_wstrb), 32'b1111);
      chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("sw_done", 32'(done), 32'd1);
      step();

      // Faults: misaligned LW, misaligned SH, illegal load funct3
      issue(1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd1);
      chk("flw_fault", 32'(fault), 32'd1);
      chk("flw_done", 32'(done), 32'd0);
      chk("flw_mvalid", 32'(mem_valid), 32'd0);
      chk("flw_wbwe", 32'(wb_we), 32'(REG_NO_WE));
      step();
      chk("flw_fault_end", 32'(fault), 32'd0);
      chk("flw_busy_end", 32'(busy), 32'd0);
      issue(1'b1, 3'b001, 32'h0000_0011, 32'h0, 5'd0);
      chk("fsh_fault", 32'(fault), 32'd1);
      chk("fsh_mvalid", 32'(mem_valid), 32'd0);
      step();
      chk("fsh_busy_end", 32'(busy), 32'd0);
      issue(1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd1);
      chk("f011_fault", 32'(fault), 32'd1);
      step();
      issue(1'b1, 3'b100, 32'h0000_0010, 32'h0, 5'd0);
      chk("fst100_fault", 32'(fault), 32'd1);
      step();
      chk("fst100_busy_end", 32'(busy), 32'd0);

      // LW to x0: completes, no register write
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd0);
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      chk("lw0_done", 32'(done), 32'd1);
      chk("lw0_wbwe", 32'(wb_we), 32'(REG_NO_WE));
      chk("lw0_wbdata", wb_data, 32'hDEAD_BEEF);
      step();

      // Reset while waiting for read data; late rvalid ignored
      issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd3);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("rw_wait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      chk_idle("rw_postrst");
      step();
      mem_rvalid = 1'b0;
      chk_idle("rw_late");
      chk("rw_late_wbdata", wb_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
